// File: rtl/simt_sched_pkg.sv
// Shared types and encodings for the divergence-aware SIMT scheduler.
package simt_sched_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StRequest = 3'd3,
    StWait    = 3'd4,
    StExecute = 3'd5,
    StUpdate  = 3'd6,
    StDone    = 3'd7
  } core_state_e;

  localparam logic [1:0] LSU_IDLE       = 2'd0;
  localparam logic [1:0] LSU_REQUESTING = 2'd1;
  localparam logic [1:0] LSU_WAITING    = 2'd2;
  localparam logic [1:0] LSU_DONE       = 2'd3;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  // A lane holds the core in WAIT while its memory access is in flight.
  function automatic logic lsu_busy(input logic [1:0] st);
    return (st == LSU_REQUESTING) || (st == LSU_WAITING);
  endfunction

endpackage

// File: rtl/simt_sched_if.sv
// Scheduler-facing bus: fetch/decode/LSU/PC-unit inputs and core control outputs.
// Optional perf counter outputs exist only when SIMT_SCHED_PERF_EN is defined.
interface simt_sched_if #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_BITS           = 8
);
  localparam int unsigned TcBits = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                 start;
  logic [TcBits-1:0]                    thread_count;
  logic [2:0]                           fetcher_state;
  logic                                 decoded_mem_read_enable;
  logic                                 decoded_mem_write_enable;
  logic                                 decoded_ret;
  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state;
  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc;

  logic [2:0]                           core_state;
  logic [PC_BITS-1:0]                   current_pc;
  logic [THREADS_PER_BLOCK-1:0]         active_mask;
  logic                                 done;
`ifdef SIMT_SCHED_PERF_EN
  logic [31:0]                          perf_cycles;
  logic [31:0]                          perf_instrs;
  logic [31:0]                          perf_divergent;
`endif

  modport master (
    input  start, thread_count, fetcher_state, decoded_mem_read_enable,
    input  decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, active_mask,
`ifdef SIMT_SCHED_PERF_EN
    output perf_cycles, perf_instrs, perf_divergent,
`endif
    output done
  );

  modport slave (
    output start, thread_count, fetcher_state, decoded_mem_read_enable,
    output decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, active_mask,
`ifdef SIMT_SCHED_PERF_EN
    input  perf_cycles, perf_instrs, perf_divergent,
`endif
    input  done
  );

endinterface

// File: rtl/simt_pc_select.sv
// Combinational min-PC reduction tree over live lanes; returns the minimum PC,
// the lanes sitting at it, and whether any lane is still live.
module simt_pc_select #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_BITS           = 8
) (
  input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] pc,
  input  logic [THREADS_PER_BLOCK-1:0]              live,
  output logic [PC_BITS-1:0]                        minpc,
  output logic [THREADS_PER_BLOCK-1:0]              match,
  output logic                                      any_live
);

  localparam int unsigned Leaves = 1 << $clog2(THREADS_PER_BLOCK);
  localparam int unsigned Nodes  = 2 * Leaves - 1;

  always_comb begin
    logic [Nodes-1:0]              vld;
    logic [Nodes-1:0][PC_BITS-1:0] val;
    vld = '0;
    val = '0;
    // Heap layout: leaves at Leaves-1.., node k has children 2k+1 and 2k+2.
    for (int unsigned j = 0; j < THREADS_PER_BLOCK; j++) begin
      vld[Leaves-1+j] = live[j];
      val[Leaves-1+j] = pc[j];
    end
    for (int k = int'(Leaves) - 2; k >= 0; k--) begin
      if (vld[2*k+1] && (!vld[2*k+2] || (val[2*k+1] <= val[2*k+2]))) begin
        val[k] = val[2*k+1];
      end else begin
        val[k] = val[2*k+2];
      end
      vld[k] = vld[2*k+1] | vld[2*k+2];
    end
    any_live = vld[0];
    minpc    = vld[0] ? val[0] : '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      match[i] = live[i] && (pc[i] == minpc);
    end
  end

endmodule

// File: rtl/simt_scheduler.sv
// Divergence-aware per-core scheduler: per-lane PCs, issue at the lowest live PC.
// Define SIMT_SCHED_PERF_EN to add cycle/instruction/divergence counters.
module simt_scheduler
  import simt_sched_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_BITS           = 8
) (
  input logic          clk,
  input logic          reset,
  simt_sched_if.master bus
);

  localparam int unsigned T = THREADS_PER_BLOCK;

  core_state_e               state_q, state_d;
  logic [T-1:0][PC_BITS-1:0] pc_q, pc_d, pc_upd;
  logic [T-1:0]              live_q, live_d, live_upd, init_live, busy_lane;
  logic [T-1:0]              mask_q, mask_d, sel_mask;
  logic [PC_BITS-1:0]        cur_pc_q, cur_pc_d, sel_min;
  logic                      done_q, done_d, sel_any, busy;

  // Per-lane views: initial live set, WAIT stall, and post-UPDATE PCs/live flags.
  always_comb begin
    int eff;
    eff = (int'(bus.thread_count) > int'(T)) ? int'(T) : int'(bus.thread_count);
    pc_upd   = pc_q;
    live_upd = live_q;
    for (int i = 0; i < int'(T); i++) begin
      init_live[i] = (i < eff);
      busy_lane[i] = mask_q[i] && lsu_busy(bus.lsu_state[2*i +: 2]);
      if (mask_q[i]) begin
        if (bus.decoded_ret) begin
          live_upd[i] = 1'b0;
        end else begin
          pc_upd[i] = bus.next_pc[i*PC_BITS +: PC_BITS];
        end
      end
    end
    busy = |busy_lane;
  end

  simt_pc_select #(
    .THREADS_PER_BLOCK(T),
    .PC_BITS          (PC_BITS)
  ) u_pc_select (
    .pc      (pc_upd),
    .live    (live_upd),
    .minpc   (sel_min),
    .match   (sel_mask),
    .any_live(sel_any)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    live_d   = live_q;
    mask_d   = mask_q;
    cur_pc_d = cur_pc_q;
    done_d   = done_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (init_live == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d  = StFetch;
            live_d   = init_live;
            pc_d     = '0;
            cur_pc_d = '0;
            mask_d   = init_live;
          end
        end
      end
      StFetch:   if (bus.fetcher_state == FETCHER_FETCHED) state_d = StDecode;
      StDecode:  state_d = StRequest;
      StRequest: state_d = StWait;
      StWait:    if (!busy) state_d = StExecute;
      StExecute: state_d = StUpdate;
      StUpdate: begin
        pc_d     = pc_upd;
        live_d   = live_upd;
        cur_pc_d = sel_min;
        if (sel_any) begin
          mask_d  = sel_mask;
          state_d = StFetch;
        end else begin
          mask_d  = '0;
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        if (!bus.start) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      live_q   <= '0;
      mask_q   <= '0;
      cur_pc_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      live_q   <= live_d;
      mask_q   <= mask_d;
      cur_pc_q <= cur_pc_d;
      done_q   <= done_d;
    end
  end

  assign bus.core_state  = state_q;
  assign bus.current_pc  = cur_pc_q;
  assign bus.active_mask = mask_q;
  assign bus.done        = done_q;

  // Only memory instructions may leave an active lane's LSU in flight during WAIT.
  a_wait_needs_mem_op: assert property (@(posedge clk) disable iff (reset)
    (state_q == StWait && !(bus.decoded_mem_read_enable || bus.decoded_mem_write_enable))
      |-> !busy);

`ifdef SIMT_SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d, div_q, div_d;

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    div_d = div_q;
    if (state_q == StIdle) begin
      if (state_d == StFetch) begin
        cyc_d = '0;
        ins_d = '0;
        div_d = '0;
      end
    end else if (state_q != StDone) begin
      cyc_d = cyc_q + 32'd1;
      if (state_q == StUpdate) begin
        ins_d = ins_q + 32'd1;
        if (sel_mask != live_upd) div_d = div_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
      div_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
      div_q <= div_d;
    end
  end

  assign bus.perf_cycles    = cyc_q;
  assign bus.perf_instrs    = ins_q;
  assign bus.perf_divergent = div_q;
`endif

endmodule

// File: tb/tb_simt_scheduler.sv
// Directed, table-driven bench for simt_scheduler with THREADS_PER_BLOCK=4, PC_BITS=8.
module tb_simt_scheduler;
  import simt_sched_pkg::*;

  localparam int unsigned T  = 4;
  localparam int unsigned PB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simt_sched_if #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) bus ();

  simt_scheduler #(
    .THREADS_PER_BLOCK(T),
    .PC_BITS          (PB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct {
    logic [7:0]  exp_pc;
    logic [3:0]  exp_mask;
    logic [31:0] npc;
    logic        ret;
    int          fw;
    int          stall;
    logic        exp_done;
  } vec_t;

  vec_t vecs [0:15];
  int   n_vec      = 0;
  int   n_miss     = 0;
  int   exp_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input logic [7:0] pc, input logic [3:0] mask, input logic [31:0] npc,
                              input logic ret, input int fw, input int stall, input logic dn);
    vec_t v;
    v.exp_pc = pc; v.exp_mask = mask; v.npc = npc; v.ret = ret;
    v.fw = fw; v.stall = stall; v.exp_done = dn;
    return v;
  endfunction

  // Walks one instruction from FETCH through UPDATE, checking every state step.
  task automatic run_instr(input vec_t v);
    check("fetch_state", {29'd0, bus.core_state}, {29'd0, StFetch});
    check("issue_pc", {24'd0, bus.current_pc}, {24'd0, v.exp_pc});
    check("issue_mask", {28'd0, bus.active_mask}, {28'd0, v.exp_mask});
    bus.fetcher_state = 3'b001;
    for (int w = 0; w < v.fw; w++) begin
      tick();
      check("fetch_hold", {29'd0, bus.core_state}, {29'd0, StFetch});
    end
    bus.fetcher_state = FETCHER_FETCHED;
    tick();
    check("decode_state", {29'd0, bus.core_state}, {29'd0, StDecode});
    bus.fetcher_state = 3'b000;
    bus.decoded_ret = v.ret;
    bus.next_pc = v.npc;
    bus.decoded_mem_read_enable = (v.stall > 0);
    tick();
    check("request_state", {29'd0, bus.core_state}, {29'd0, StRequest});
    // Lane 1 stalls; lane 3 also reports busy but is outside the thread count.
    if (v.stall > 0) bus.lsu_state = {LSU_WAITING, LSU_DONE, LSU_WAITING, LSU_DONE};
    tick();
    if (v.stall == 0) begin
      check("wait_state", {29'd0, bus.core_state}, {29'd0, StWait});
      tick();
    end else begin
      for (int k = 1; k <= v.stall; k++) begin
        check("wait_stall", {29'd0, bus.core_state}, {29'd0, StWait});
        if (k == v.stall) bus.lsu_state = {LSU_WAITING, LSU_DONE, LSU_DONE, LSU_DONE};
        tick();
      end
    end
    check("execute_state", {29'd0, bus.core_state}, {29'd0, StExecute});
    tick();
    check("update_state", {29'd0, bus.core_state}, {29'd0, StUpdate});
    check("mask_stable", {28'd0, bus.active_mask}, {28'd0, v.exp_mask});
    tick();
    exp_cycles += v.fw + 5 + ((v.stall > 0) ? v.stall : 1);
    if (v.exp_done) begin
      check("end_state", {29'd0, bus.core_state}, {29'd0, StDone});
      check("end_done", {31'd0, bus.done}, 32'd1);
      check("end_mask", {28'd0, bus.active_mask}, 32'd0);
    end else begin
      check("next_state", {29'd0, bus.core_state}, {29'd0, StFetch});
      check("next_done", {31'd0, bus.done}, 32'd0);
    end
    bus.decoded_ret = 1'b0;
    bus.decoded_mem_read_enable = 1'b0;
    bus.lsu_state = '0;
  endtask

  task automatic start_kernel(input int tc);
    bus.thread_count = 3'(tc);
    bus.start = 1'b1;
    tick();
    exp_cycles = 0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_instr(vecs[i]);
  endtask

  task automatic end_kernel;
    tick();
    check("done_hold_state", {29'd0, bus.core_state}, {29'd0, StDone});
    check("done_hold", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b0;
    tick();
    check("idle_after_done", {29'd0, bus.core_state}, {29'd0, StIdle});
    check("done_cleared", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.thread_count = '0;
    bus.fetcher_state = 3'b000;
    bus.decoded_mem_read_enable = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    bus.decoded_ret = 1'b0;
    bus.lsu_state = '0;
    bus.next_pc = '0;

    // Uniform flow
    vecs[0]  = mk(8'd0, 4'b1111, pack4(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 0, 0, 1'b0);
    vecs[1]  = mk(8'd1, 4'b1111, pack4(8'd2, 8'd2, 8'd2, 8'd2), 1'b0, 2, 0, 1'b0);
    vecs[2]  = mk(8'd2, 4'b1111, pack4(8'd3, 8'd3, 8'd3, 8'd3), 1'b0, 0, 0, 1'b0);
    vecs[3]  = mk(8'd3, 4'b1111, 32'd0, 1'b1, 1, 0, 1'b1);
    // Divergence and reconvergence; inactive lanes carry junk next_pc
    vecs[4]  = mk(8'd0, 4'b1111, pack4(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 0, 0, 1'b0);
    vecs[5]  = mk(8'd1, 4'b1111, pack4(8'd2, 8'd2, 8'd2, 8'd2), 1'b0, 0, 0, 1'b0);
    vecs[6]  = mk(8'd2, 4'b1111, pack4(8'd5, 8'd5, 8'd3, 8'd3), 1'b0, 0, 0, 1'b0);
    vecs[7]  = mk(8'd3, 4'b1100, pack4(8'hEE, 8'hEE, 8'd4, 8'd4), 1'b0, 1, 0, 1'b0);
    vecs[8]  = mk(8'd4, 4'b1100, pack4(8'hEE, 8'hEE, 8'd5, 8'd5), 1'b0, 0, 0, 1'b0);
    vecs[9]  = mk(8'd5, 4'b1111, 32'd0, 1'b1, 0, 0, 1'b1);
    // Partial RET
    vecs[10] = mk(8'd0, 4'b1111, pack4(8'd4, 8'd6, 8'd4, 8'd6), 1'b0, 0, 0, 1'b0);
    vecs[11] = mk(8'd4, 4'b0101, pack4(8'hAA, 8'hAA, 8'hAA, 8'hAA), 1'b1, 0, 0, 1'b0);
    vecs[12] = mk(8'd6, 4'b1010, 32'd0, 1'b1, 0, 0, 1'b1);
    // Memory wait with eff=3
    vecs[13] = mk(8'd0, 4'b0111, pack4(8'd9, 8'd9, 8'd9, 8'd9), 1'b0, 0, 7, 1'b0);
    vecs[14] = mk(8'd9, 4'b0111, 32'd0, 1'b1, 0, 0, 1'b1);
    // Overflowing thread count saturates to all lanes
    vecs[15] = mk(8'd0, 4'b1111, 32'd0, 1'b1, 0, 0, 1'b1);

    tick();
    tick();
    check("rst_state", {29'd0, bus.core_state}, {29'd0, StIdle});
    check("rst_pc", {24'd0, bus.current_pc}, 32'd0);
    check("rst_mask", {28'd0, bus.active_mask}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_start", {29'd0, bus.core_state}, {29'd0, StIdle});

    start_kernel(4);
    run_range(0, 3);
    end_kernel();

    start_kernel(4);
    run_range(4, 9);
`ifdef SIMT_SCHED_PERF_EN
    check("perf_instrs", bus.perf_instrs, 32'd6);
    check("perf_divergent", bus.perf_divergent, 32'd2);
    check("perf_cycles", bus.perf_cycles, 32'(exp_cycles));
    tick();
    check("perf_cycles_frozen", bus.perf_cycles, 32'(exp_cycles));
`endif
    end_kernel();

    start_kernel(4);
    run_range(10, 12);
    end_kernel();

    start_kernel(3);
    run_range(13, 14);
    end_kernel();

    start_kernel(7);
    run_range(15, 15);
    end_kernel();

    // Zero threads: straight to DONE
    start_kernel(0);
    check("zero_state", {29'd0, bus.core_state}, {29'd0, StDone});
    check("zero_done", {31'd0, bus.done}, 32'd1);
    end_kernel();

    // Reset in the middle of a memory wait
    start_kernel(4);
    bus.fetcher_state = FETCHER_FETCHED;
    tick();
    bus.fetcher_state = 3'b000;
    bus.decoded_mem_read_enable = 1'b1;
    tick();
    bus.lsu_state = {LSU_WAITING, LSU_WAITING, LSU_WAITING, LSU_WAITING};
    tick();
    tick();
    check("midwait_state", {29'd0, bus.core_state}, {29'd0, StWait});
    reset = 1'b1;
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_state", {29'd0, bus.core_state}, {29'd0, StIdle});
    check("abort_mask", {28'd0, bus.active_mask}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
`ifdef SIMT_SCHED_PERF_EN
    check("abort_perf_cycles", bus.perf_cycles, 32'd0);
`endif
    bus.lsu_state = '0;
    bus.decoded_mem_read_enable = 1'b0;
    tick();
    check("abort_stays_idle", {29'd0, bus.core_state}, {29'd0, StIdle});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
